// File: rtl/seq_divider16x8_pkg.sv
// Shared definitions for the sequential 2*DW / DW restoring divider.
package seq_divider16x8_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter must be able to hold the value DW.
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/seq_divider16x8_if.sv
// Start/busy/done handshake plus operand and result bus of the divider.
interface seq_divider16x8_if
  import seq_divider16x8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic            start;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            busy;
  logic            done;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            overflow;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );

endinterface

// File: rtl/seq_divider16x8_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder
// and subtract the divisor when it fits.
module seq_divider16x8_div_step
  import seq_divider16x8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] rem,
  input  logic          bit_in,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic          qbit
);

  logic [DW:0] t;
  logic [DW:0] diff;

  // rem < divisor on entry, so t - divisor always fits back into DW bits.
  assign t        = {rem, bit_in};
  assign diff     = t - {1'b0, divisor};
  assign qbit     = (t >= {1'b0, divisor});
  assign rem_next = qbit ? diff[DW-1:0] : t[DW-1:0];

endmodule

// File: rtl/seq_divider16x8.sv
// Multi-cycle restoring divider: 2*DW-bit dividend / DW-bit divisor, one
// quotient bit per cycle, with overflow and divide-by-zero detection.
module seq_divider16x8
  import seq_divider16x8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input logic clk,
  input logic rst,
  seq_divider16x8_if.slave bus
);

  localparam int CNT_W = cnt_width(DW);

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    rem_q;
  logic [DW-1:0]    shift_q;
  logic [DW-1:0]    divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_pending;
  logic             dbz_pending;
  logic             done_q;
  logic [DW-1:0]    quotient_q;
  logic [DW-1:0]    remainder_q;
  logic             overflow_q;
  logic             div_by_zero_q;

  logic             accept;
  logic             err_zero;
  logic             err_ovf;
  logic [DW-1:0]    rem_next;
  logic             qbit;

  assign accept   = (state == IDLE) && bus.start;
  assign err_zero = (bus.divisor == '0);
  assign err_ovf  = !err_zero && (bus.dividend[2*DW-1:DW] >= bus.divisor);

  seq_divider16x8_div_step #(.DW(DW)) u_step (
    .rem      (rem_q),
    .bit_in   (shift_q[DW-1]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = (err_zero || err_ovf) ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(DW - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The shift register doubles as the quotient: dividend bits leave at the MSB
  // while quotient bits enter at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q         <= '0;
      shift_q       <= '0;
      divisor_q     <= '0;
      cnt_q         <= '0;
      ovf_pending   <= 1'b0;
      dbz_pending   <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            divisor_q     <= bus.divisor;
            cnt_q         <= '0;
            ovf_pending   <= err_ovf;
            dbz_pending   <= err_zero;
            quotient_q    <= '0;
            remainder_q   <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            if (err_zero || err_ovf) begin
              rem_q   <= '0;
              shift_q <= '0;
            end else begin
              rem_q   <= bus.dividend[2*DW-1:DW];
              shift_q <= bus.dividend[DW-1:0];
            end
          end
        end
        CALC: begin
          rem_q   <= rem_next;
          shift_q <= {shift_q[DW-2:0], qbit};
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          quotient_q    <= shift_q;
          remainder_q   <= rem_q;
          overflow_q    <= ovf_pending;
          div_by_zero_q <= dbz_pending;
          done_q        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider16x8.sv
// Self-checking bench for seq_divider16x8: directed vector table, handshake
// corner sequences and randomized operands against an arithmetic model.
module tb_seq_divider16x8;

  localparam int DW = 8;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst;
  int   n_compared = 0;
  int   n_mismatched = 0;

  seq_divider16x8_if #(.DW(DW)) bus ();

  seq_divider16x8 #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    bit          ov;
    bit          dz;
    int          lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Quotient/remainder straight from integer division; error cases report zero.
  function automatic void refModel(input logic [15:0] a, input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output bit ov, output bit dz, output int lat);
    int unsigned ai = a;
    int unsigned bi = b;
    dz = (bi == 0);
    ov = !dz && ((ai / bi) > 255);
    if (dz || ov) begin
      q   = 8'd0;
      r   = 8'd0;
      lat = 1;
    end else begin
      q   = 8'(ai / bi);
      r   = 8'(ai % bi);
      lat = 9;
    end
  endfunction

  // Called at posedge+1 just after the accept edge; counts cycles until done.
  task automatic waitDone(output int lat, output bit got, output bit busy_ok);
    lat     = 0;
    got     = 1'b0;
    busy_ok = bus.busy && !bus.done;
    while (!got && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) got = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                               output int lat, output bit got, output bit busy_ok,
                               output bit busy_at_done, output logic [7:0] q,
                               output logic [7:0] r, output bit ov, output bit dz,
                               output bit pulse_ok);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone(lat, got, busy_ok);
    busy_at_done = bus.busy;
    q  = bus.quotient;
    r  = bus.remainder;
    ov = bus.overflow;
    dz = bus.div_by_zero;
    @(posedge clk); #1;
    pulse_ok = !bus.done;
  endtask

  task automatic runCase(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input bit eov, input bit edz, input int elat);
    int lat;
    bit got, busy_ok, busy_at_done, pulse_ok, ov, dz;
    logic [7:0] q, r;
    applyStimulus(a, b, lat, got, busy_ok, busy_at_done, q, r, ov, dz, pulse_ok);
    checkOutput({tag, " done_seen"}, 32'(got), 32'd1);
    checkOutput({tag, " quotient"}, 32'(q), 32'(eq));
    checkOutput({tag, " remainder"}, 32'(r), 32'(er));
    checkOutput({tag, " overflow"}, 32'(ov), 32'(eov));
    checkOutput({tag, " div_by_zero"}, 32'(dz), 32'(edz));
    checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
    checkOutput({tag, " busy_in_flight"}, 32'(busy_ok), 32'd1);
    checkOutput({tag, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    checkOutput({tag, " done_one_cycle"}, 32'(pulse_ok), 32'd1);
  endtask

  initial begin
    vec_t vecs[$];
    int lat;
    bit got, busy_ok;
    logic [7:0] q, r;
    bit ov, dz;
    int elat;

    vecs.push_back('{16'd1,     8'd1,   8'd1,   8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd45,    8'd5,   8'd9,   8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd24,    8'd6,   8'd4,   8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd65025, 8'd255, 8'd255, 8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd1000,  8'd7,   8'd142, 8'd6, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd256,   8'd1,   8'd0,   8'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{16'd100,   8'd0,   8'd0,   8'd0, 1'b0, 1'b1, 1});
    vecs.push_back('{16'd65535, 8'd255, 8'd0,   8'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{16'd0,     8'd5,   8'd0,   8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd255,   8'd1,   8'd255, 8'd0, 1'b0, 1'b0, 9});
    vecs.push_back('{16'd65279, 8'd255, 8'd255, 8'd254, 1'b0, 1'b0, 9});

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    @(posedge clk); #1;
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset quotient", 32'(bus.quotient), 32'd0);
    checkOutput("reset remainder", 32'(bus.remainder), 32'd0);
    checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
    checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      runCase($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].ov, vecs[i].dz, vecs[i].lat);
    end

    // Results must hold through idle cycles until the next accept.
    runCase("hold", 16'd1000, 8'd7, 8'd142, 8'd6, 1'b0, 1'b0, 9);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold quotient", 32'(bus.quotient), 32'd142);
    checkOutput("hold remainder", 32'(bus.remainder), 32'd6);

    $display("[TB] start re-pulsed mid-calculation");
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < MAX_WAIT) begin
      bus.start = (lat == 3);
      if (lat == 3) begin
        bus.dividend = 16'd45;
        bus.divisor  = 8'd5;
      end
      @(posedge clk); #1;
      lat++;
      got = bus.done;
    end
    bus.start = 1'b0;
    checkOutput("repulse done_seen", 32'(got), 32'd1);
    checkOutput("repulse latency", 32'(lat), 32'd9);
    checkOutput("repulse quotient", 32'(bus.quotient), 32'd142);
    checkOutput("repulse remainder", 32'(bus.remainder), 32'd6);
    @(posedge clk); #1;
    checkOutput("repulse not_queued", 32'(bus.busy), 32'd0);

    $display("[TB] back-to-back with start held");
    bus.dividend = 16'd24;
    bus.divisor  = 8'd6;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    waitDone(lat, got, busy_ok);
    checkOutput("b2b first latency", 32'(lat), 32'd9);
    checkOutput("b2b first quotient", 32'(bus.quotient), 32'd4);
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    @(posedge clk); #1;
    checkOutput("b2b relaunch busy", 32'(bus.busy), 32'd1);
    checkOutput("b2b relaunch done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    waitDone(lat, got, busy_ok);
    checkOutput("b2b second latency", 32'(lat), 32'd9);
    checkOutput("b2b second quotient", 32'(bus.quotient), 32'd142);
    checkOutput("b2b second remainder", 32'(bus.remainder), 32'd6);
    @(posedge clk); #1;

    $display("[TB] reset mid-calculation");
    runCase("prereset", 16'd45, 8'd5, 8'd9, 8'd0, 1'b0, 1'b0, 9);
    bus.dividend = 16'd65025;
    bus.divisor  = 8'd255;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset done", 32'(bus.done), 32'd0);
    checkOutput("midreset quotient", 32'(bus.quotient), 32'd0);
    checkOutput("midreset remainder", 32'(bus.remainder), 32'd0);
    checkOutput("midreset overflow", 32'(bus.overflow), 32'd0);
    checkOutput("midreset div_by_zero", 32'(bus.div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    runCase("postreset", 16'd6, 8'd3, 8'd2, 8'd0, 1'b0, 1'b0, 9);

    $display("[TB] randomized operands");
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      b   = 8'($urandom_range(1, 255));
      if (sel == 0) begin
        b = 8'd0;
        a = 16'($urandom);
      end else if (sel == 1) begin
        a = 16'($urandom);
      end else begin
        a = 16'($urandom_range(0, int'(b) * 256 - 1));
      end
      refModel(a, b, q, r, ov, dz, elat);
      runCase($sformatf("rand%0d %0d/%0d", i, a, b), a, b, q, r, ov, dz, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
